// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 8-bit memory port: CPU has fixed priority, DMA is protected by a starvation counter.
// Optional macro ARB_LOCK_EN adds cpu_lock, which chains locked CPU transfers back to back without returning to IDLE.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_write,
`ifdef ARB_LOCK_EN
  input  logic              cpu_lock,
`endif
  output logic              cpu_gnt,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_write,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter is 4 bits wide, which bounds the legal STARVE_LIMIT to 1..15.
  localparam int unsigned      CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CPU_ADDR = 3'd1;
  localparam logic [2:0] ST_CPU_DATA = 3'd2;
  localparam logic [2:0] ST_DMA_ADDR = 3'd3;
  localparam logic [2:0] ST_DMA_DATA = 3'd4;

  logic [2:0]        state_q,      state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              wr_q,         wr_d;
  logic              cpu_gnt_q,    cpu_gnt_d;
  logic              cpu_ack_q,    cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
  logic              dma_gnt_q,    dma_gnt_d;
  logic              dma_ack_q,    dma_ack_d;
  logic [DATA_W-1:0] dma_rdata_q,  dma_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic              mem_write_q,  mem_write_d;

  logic starved_c;
  logic lock_hold_c;

  assign starved_c = (starve_cnt_q >= LIMIT);

`ifdef ARB_LOCK_EN
  assign lock_hold_c = cpu_lock & cpu_req;
`else
  assign lock_hold_c = 1'b0;
`endif

  // Next-state and registered-output logic; address-beat outputs are loaded on entry to x_ADDR.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wr_d         = wr_q;
    cpu_gnt_d    = 1'b0;
    cpu_ack_d    = 1'b0;
    dma_gnt_d    = 1'b0;
    dma_ack_d    = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (!dma_req) begin
          starve_cnt_d = '0;
        end
        if (cpu_req && !(dma_req && starved_c)) begin
          state_d     = ST_CPU_ADDR;
          cpu_gnt_d   = 1'b1;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_write_d = cpu_write;
          wr_d        = cpu_write;
          // A CPU win over a waiting DMA moves DMA one step closer to a forced grant.
          if (dma_req) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else if (dma_req) begin
          state_d      = ST_DMA_ADDR;
          dma_gnt_d    = 1'b1;
          mem_addr_d   = dma_addr;
          mem_wdata_d  = dma_wdata;
          mem_write_d  = dma_write;
          wr_d         = dma_write;
          starve_cnt_d = '0;
        end
      end

      ST_CPU_ADDR: begin
        state_d   = ST_CPU_DATA;
        cpu_gnt_d = 1'b1;
        cpu_ack_d = 1'b1;
      end

      ST_CPU_DATA: begin
        if (!wr_q) begin
          cpu_rdata_d = mem_rdata;
        end
        // A locked CPU keeps the port and skips arbitration entirely.
        if (lock_hold_c) begin
          state_d     = ST_CPU_ADDR;
          cpu_gnt_d   = 1'b1;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_write_d = cpu_write;
          wr_d        = cpu_write;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DMA_ADDR: begin
        state_d   = ST_DMA_DATA;
        dma_gnt_d = 1'b1;
        dma_ack_d = 1'b1;
      end

      ST_DMA_DATA: begin
        if (!wr_q) begin
          dma_rdata_d = mem_rdata;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and outputs clear asynchronously, so an in-flight write strobe drops immediately.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      wr_q         <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_gnt_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      dma_rdata_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wr_q         <= wr_d;
      cpu_gnt_q    <= cpu_gnt_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_gnt_q    <= dma_gnt_d;
      dma_ack_q    <= dma_ack_d;
      dma_rdata_q  <= dma_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_gnt   = dma_gnt_q;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a transfer-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int          LIM = 3;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          cpu_req, cpu_write, dma_req, dma_write;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, cpu_ack, dma_gnt, dma_ack, mem_write;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef ARB_LOCK_EN
  logic          cpu_lock;
`endif

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_write (cpu_write),
`ifdef ARB_LOCK_EN
    .cpu_lock  (cpu_lock),
`endif
    .cpu_gnt   (cpu_gnt),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_write (dma_write),
    .dma_gnt   (dma_gnt),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [7:0] init_byte(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // Memory behind the port: registered read, one-cycle latency.
  logic [7:0] mem     [256];
  bit         wr_seen [256];
  always @(posedge Clk) begin
    if (mem_write) begin
      mem[mem_addr]     <= mem_wdata;
      wr_seen[mem_addr] <= 1'b1;
    end
    mem_rdata <= wr_seen[mem_addr] ? mem[mem_addr] : init_byte(mem_addr);
  end

  // Transfer-level model: a grant at edge g owns the port for edges g+1 (data) and g+2 (done).
  logic [7:0] mdl_mem [256];
  int         e, g_edge, owner, wins;
  logic [7:0] x_addr, x_wdata;
  logic       x_write;
  logic [7:0] exp_cpu_rdata, exp_dma_rdata;
  int         total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic grant(input int w);
    owner   = w;
    g_edge  = e;
    x_addr  = (w == 1) ? cpu_addr  : dma_addr;
    x_wdata = (w == 1) ? cpu_wdata : dma_wdata;
    x_write = (w == 1) ? cpu_write : dma_write;
  endtask

  function automatic logic lock_now();
`ifdef ARB_LOCK_EN
    return cpu_lock && cpu_req;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    owner = 0; wins = 0; exp_cpu_rdata = '0; exp_dma_rdata = '0;
  endtask

  task automatic model_edge();
    int age;
    e++;
    if (owner != 0) begin
      age = e - g_edge;
      if (age == 1 && x_write) mdl_mem[x_addr] = x_wdata;
      if (age == 2) begin
        if (!x_write) begin
          if (owner == 1) exp_cpu_rdata = mdl_mem[x_addr];
          else            exp_dma_rdata = mdl_mem[x_addr];
        end
        if (owner == 1 && lock_now()) grant(1);
        else owner = 0;
      end
    end else begin
      if (!dma_req) wins = 0;
      if (cpu_req && !(dma_req && wins >= LIM)) begin
        if (dma_req && wins < LIM) wins = wins + 1;
        grant(1);
      end else if (dma_req) begin
        wins = 0;
        grant(2);
      end
    end
  endtask

  task automatic check_cycle();
    int age;
    age = e - g_edge;
    chk("cpu_gnt",   cpu_gnt,   owner == 1);
    chk("dma_gnt",   dma_gnt,   owner == 2);
    chk("cpu_ack",   cpu_ack,   owner == 1 && age == 1);
    chk("dma_ack",   dma_ack,   owner == 2 && age == 1);
    chk("mem_write", mem_write, owner != 0 && age == 0 && x_write);
    if (owner != 0 && age == 0) begin
      chk("mem_addr",  mem_addr,  x_addr);
      chk("mem_wdata", mem_wdata, x_wdata);
    end
    chk("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    chk("dma_rdata", dma_rdata, exp_dma_rdata);
    chk("gnt_excl",  cpu_gnt & dma_gnt, 0);
    chk("ack_excl",  cpu_ack & dma_ack, 0);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check_cycle();
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; dma_req = 1'b0; cpu_write = 1'b0; dma_write = 1'b0;
`ifdef ARB_LOCK_EN
    cpu_lock = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check_cycle();
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  // Records grant starts over a window of held contention and checks them against C,C,C,D repeating.
  task automatic run_contention(input int ticks, input int nexp, input string tag);
    int   order [16];
    int   n;
    logic pc, pd;
    n = 0; pc = 1'b0; pd = 1'b0;
    for (int i = 0; i < ticks; i++) begin
      tick();
      if (n < 16 && cpu_gnt && !pc) begin order[n] = 1; n++; end
      if (n < 16 && dma_gnt && !pd) begin order[n] = 2; n++; end
      pc = cpu_gnt; pd = dma_gnt;
    end
    chk({tag, "_count"}, n, nexp);
    for (int i = 0; i < n && i < nexp; i++)
      chk({tag, "_order"}, order[i], ((i % (LIM + 1)) == LIM) ? 2 : 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnt_run;
    total = 0; bad = 0; e = 0; g_edge = 0; x_addr = '0; x_wdata = '0; x_write = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) mdl_mem[i] = init_byte(8'(i));
    idle_inputs();
    cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0;
    Reset = 1'b0;
    #2;
    apply_reset();

    // CPU read of 0x10
    cpu_req = 1'b1; cpu_addr = 8'h10; cpu_write = 1'b0; cpu_wdata = 8'($urandom);
    tick();
    chk("cpu_rd_addr", mem_addr, 8'h10);
    chk("cpu_rd_gnt1", cpu_gnt, 1);
    tick();
    chk("cpu_rd_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    tick();
    chk("cpu_rd_data", cpu_rdata, 8'hA5);
    chk("cpu_rd_gnt_off", cpu_gnt, 0);
    repeat (2) tick();
    chk("cpu_rd_hold", cpu_rdata, 8'hA5);

    // DMA write 0x3C to 0x20
    dma_req = 1'b1; dma_addr = 8'h20; dma_wdata = 8'h3C; dma_write = 1'b1;
    tick();
    chk("dma_wr_strobe", mem_write, 1);
    chk("dma_wr_addr", mem_addr, 8'h20);
    chk("dma_wr_data", mem_wdata, 8'h3C);
    tick();
    chk("dma_wr_ack", dma_ack, 1);
    chk("dma_wr_strobe_off", mem_write, 0);
    dma_req = 1'b0; dma_write = 1'b0;
    repeat (2) tick();
    chk("dma_wr_mem", mem[8'h20], 8'h3C);

    // Held contention from a cleared starvation count
    cpu_req = 1'b1; cpu_addr = 8'h33; dma_req = 1'b1; dma_addr = 8'h44;
    run_contention(24, 8, "contend");
    idle_inputs();
    repeat (3) tick();

    // Simultaneous first request out of reset
    apply_reset();
    cpu_req = 1'b1; cpu_addr = 8'h51; dma_req = 1'b1; dma_addr = 8'h62;
    run_contention(12, 4, "first");
    idle_inputs();
    repeat (3) tick();

    // Reset during the address beat of a DMA write aborts it
    dma_req = 1'b1; dma_addr = 8'h40; dma_wdata = 8'h99; dma_write = 1'b1;
    tick();
    chk("abort_strobe_pre", mem_write, 1);
    idle_inputs();
    Reset = 1'b1;
    #1;
    model_reset();
    chk("abort_strobe_async", mem_write, 0);
    chk("abort_gnt_async", dma_gnt, 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (3) begin
      tick();
      chk("abort_no_ack", dma_ack, 0);
    end
    chk("abort_no_write", wr_seen[8'h40], 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cpu_req   = ($urandom_range(0, 9) < 6);
      dma_req   = ($urandom_range(0, 9) < 5);
      cpu_addr  = 8'($urandom); cpu_wdata = 8'($urandom); cpu_write = 1'($urandom);
      dma_addr  = 8'($urandom); dma_wdata = 8'($urandom); dma_write = 1'($urandom);
`ifdef ARB_LOCK_EN
      cpu_lock  = ($urandom_range(0, 3) == 0);
`endif
      tick();
    end
    idle_inputs();
    repeat (4) tick();

`ifdef ARB_LOCK_EN
    // Locked CPU keeps the port across two transfers while DMA waits
    cpu_lock = 1'b1; cpu_req = 1'b1; cpu_addr = 8'h70; dma_req = 1'b1; dma_addr = 8'h71;
    gnt_run = 0;
    repeat (4) begin
      tick();
      if (cpu_gnt) gnt_run++;
    end
    chk("lock_no_idle", gnt_run, 4);
    cpu_lock = 1'b0; cpu_req = 1'b0;
    tick();
    chk("lock_release_gnt", cpu_gnt, 0);
    tick();
    chk("lock_dma_after", dma_gnt, 1);
    idle_inputs();
    repeat (4) tick();
`else
    gnt_run = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
